// File: rtl/bias_accum_out_pkg.sv
// Shared lane geometry and saturation limits for the bias/accumulate output stage.
package bias_accum_out_pkg;

    localparam int LANE_W  = 18;
    localparam int N_LANES = 16;

    localparam logic [LANE_W-1:0] SAT_MAX = 18'h1FFFF;
    localparam logic [LANE_W-1:0] SAT_MIN = 18'h20000;

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    function automatic int lane_hi(input int lane, input int w);
        return lane * w + w - 1;
    endfunction

endpackage

// File: rtl/bias_accum_out_sat_add_lane.sv
// One lane of W-bit signed saturating addition; ovf flags either clamp.
module sat_add_lane
    import bias_accum_out_pkg::*;
#(
    parameter int W = LANE_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);

    logic signed [W:0] sum_p0;

    // Top two bits of the widened sum disagree exactly when the W-bit result overflows.
    function automatic logic signed [W-1:0] sat(input logic signed [W:0] s);
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
    endfunction

    assign sum_p0 = {a[W-1], a} + {b[W-1], b};
    assign y      = sat(sum_p0);
    assign ovf    = sum_p0[W] ^ sum_p0[W-1];

endmodule

// File: rtl/bias_accum_out.sv
// Folds bias into the first pass, accumulates later passes with saturation,
// applies optional ReLU and hands the finished vector downstream via valid/ready.
module bias_accum_out
    import bias_accum_out_pkg::*;
#(
    parameter int N_adder_tree = N_LANES,
    parameter int W            = LANE_W,
    parameter int CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_adder_tree*W-1:0] bias_in,
    input  logic                      relu_en,
    input  logic [N_adder_tree*W-1:0] psum_in,
    input  logic                      psum_valid,
    input  logic                      psum_last,
    output logic                      psum_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic                      sat_flag
);

    logic [N_adder_tree*W-1:0] acc_p1;
    logic                      first_p1;
    logic [N_adder_tree*W-1:0] sum_p0;
    logic [N_adder_tree*W-1:0] res_p0;
    logic [N_adder_tree-1:0]   ovf_p0;
    logic                      accept_p0;

    assign psum_ready = !(out_valid && !out_ready);
    assign accept_p0  = psum_valid && psum_ready;

    // Stage p0: per-lane operand select, saturating add, ReLU
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic signed [W-1:0] opa;
        logic signed [W-1:0] psum;
        logic signed [W-1:0] sum;
        logic                ovf;

        assign opa  = first_p1 ? bias_in[lane_lo(i, W) +: W] : acc_p1[lane_lo(i, W) +: W];
        assign psum = psum_in[lane_lo(i, W) +: W];

        sat_add_lane #(.W(W)) u_add (
            .a   (opa),
            .b   (psum),
            .y   (sum),
            .ovf (ovf)
        );

        assign sum_p0[lane_hi(i, W):lane_lo(i, W)] = sum;
        assign res_p0[lane_hi(i, W):lane_lo(i, W)] = (relu_en && sum[W-1]) ? '0 : sum;
        assign ovf_p0[i] = ovf;
    end

    // Stage p1: accumulator, pass tracking and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1    <= '0;
            first_p1  <= 1'b1;
            pass_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (accept_p0) begin
                acc_p1   <= sum_p0;
                sat_flag <= sat_flag | (|ovf_p0);
                if (psum_last) begin
                    first_p1  <= 1'b1;
                    pass_cnt  <= '0;
                    out_data  <= res_p0;
                    out_valid <= 1'b1;
                end else begin
                    first_p1 <= 1'b0;
                    pass_cnt <= pass_cnt + 1'b1;
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bias_accum_out.sv
// Directed checks of bias folding, multi-pass accumulation, ReLU, saturation,
// backpressure and asynchronous reset for bias_accum_out.
module tb_bias_accum_out;
    import bias_accum_out_pkg::*;

    localparam int N = 16;
    localparam int W = 18;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  bias_in;
    logic            relu_en;
    logic [N*W-1:0]  psum_in;
    logic            psum_valid;
    logic            psum_last;
    logic            psum_ready;
    logic [N*W-1:0]  out_data;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   pass_cnt;
    logic            sat_flag;

    int total = 0;
    int bad = 0;

    bias_accum_out #(.N_adder_tree(N), .W(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bias_in    (bias_in),
        .relu_en    (relu_en),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_last  (psum_last),
        .psum_ready (psum_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pass_cnt   (pass_cnt),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] lane(input logic [N*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ln, input int val, input logic last);
        psum_in = '0;
        psum_in[ln*W +: W] = W'(val);
        psum_valid = 1'b1;
        psum_last = last;
    endtask

    initial begin
        rst_n = 1'b0;
        relu_en = 1'b0;
        psum_in = '0;
        psum_valid = 1'b0;
        psum_last = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) bias_in[i*W +: W] = W'(i * 10);
        bias_in[0*W +: W] = W'(2784);
        bias_in[3*W +: W] = W'(-8);

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", (out_data == '0), 1);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_psum_ready", psum_ready, 1);
        tick();
        rst_n = 1'b1;

        // Single-pass vector
        put(0, 100, 1'b1);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_lane0", lane(out_data, 0), 2884);
        chk("single_lane5", lane(out_data, 5), 50);
        chk("single_cnt", pass_cnt, 0);
        psum_valid = 1'b0;
        psum_last = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_hold", lane(out_data, 0), 2884);

        // Three passes on lane 3
        put(3, 5, 1'b0);
        tick();
        chk("pass1_cnt", pass_cnt, 1);
        chk("pass1_novalid", out_valid, 0);
        put(3, 6, 1'b0);
        tick();
        chk("pass2_cnt", pass_cnt, 2);
        put(3, 7, 1'b1);
        tick();
        chk("pass3_valid", out_valid, 1);
        chk("pass3_lane3", lane(out_data, 3), 10);
        chk("pass3_lane0", lane(out_data, 0), 2784);
        chk("pass3_cnt", pass_cnt, 0);

        // ReLU on and off, back to back
        relu_en = 1'b1;
        put(3, -100, 1'b1);
        tick();
        chk("relu_lane3", lane(out_data, 3), 0);
        chk("relu_lane0", lane(out_data, 0), 2784);
        relu_en = 1'b0;
        put(3, -100, 1'b1);
        tick();
        chk("norelu_lane3", lane(out_data, 3), -108);
        chk("nosat_flag", sat_flag, 0);

        // Saturation both directions
        put(0, 131000, 1'b1);
        tick();
        chk("satpos_lane0", lane(out_data, 0), signed'(SAT_MAX));
        chk("satpos_flag", sat_flag, 1);
        put(3, -131070, 1'b1);
        tick();
        chk("satneg_lane3", lane(out_data, 3), signed'(SAT_MIN));
        put(0, 1, 1'b1);
        tick();
        chk("sat_sticky", sat_flag, 1);
        chk("after_sat_lane0", lane(out_data, 0), 2785);

        // Backpressure
        out_ready = 1'b0;
        put(0, 1, 1'b1);
        tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_ready", psum_ready, 0);
        put(0, 50, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", lane(out_data, 0), 2785);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", psum_ready, 1);
        tick();
        chk("bp_release_valid", out_valid, 1);
        chk("bp_release_data", lane(out_data, 0), 2834);
        psum_valid = 1'b0;
        psum_last = 1'b0;
        tick();
        chk("bp_drain_valid", out_valid, 0);

        // Last without valid is ignored
        psum_last = 1'b1;
        tick();
        chk("ignored_last_valid", out_valid, 0);
        chk("ignored_last_cnt", pass_cnt, 0);

        // Reset mid-vector
        put(0, 1, 1'b0);
        tick();
        tick();
        chk("mid_cnt", pass_cnt, 2);
        psum_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", (out_data == '0), 1);
        chk("arst_cnt", pass_cnt, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_sat", sat_flag, 0);
        tick();
        rst_n = 1'b1;
        put(0, 1, 1'b1);
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_lane0", lane(out_data, 0), 2785);
        psum_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
